// File: rtl/clk_div_bank.sv
// Bank of N_CH programmable clock-enable dividers with glitch-free shadowed
// reconfiguration, a global phase-sync restart and a config-settled lock flag.
module clk_div_bank #(
  parameter int N_CH        = 8,
  parameter int DIV_W       = 16,
  parameter int DEF_DIV     = 10,
  parameter int LOCK_CYCLES = 16
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             cfg_wr,
  input  logic [3:0]       cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
  input  logic             sync_i,
  output logic [N_CH-1:0]  tick_o,
  output logic [N_CH-1:0]  clk_o,
  output logic [N_CH-1:0]  pending_o,
  output logic             cfg_err,
  output logic             locked
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam logic [DIV_W-1:0] ZERO_V    = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE_V     = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
  localparam logic [LCW-1:0]   LOCK_V    = LCW'(LOCK_CYCLES);
  localparam logic [LCW-1:0]   LCNT_ONE  = LCW'(1);

  // Start value for a freshly applied ratio; never lets cnt exceed div-1.
  function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] phase,
                                                   input logic [DIV_W-1:0] div);
    if (div == ZERO_V)     return ZERO_V;
    else if (phase >= div) return div - ONE_V;
    else                   return phase;
  endfunction

  function automatic logic tick_level(input logic [DIV_W-1:0] cnt,
                                      input logic [DIV_W-1:0] div);
    return (div != ZERO_V) && (cnt == div - ONE_V);
  endfunction

  // High for the first ceil(div/2) counts; extra bit avoids overflow at max div.
  function automatic logic clk_level(input logic [DIV_W-1:0] cnt,
                                     input logic [DIV_W-1:0] div);
    logic [DIV_W:0] half;
    half = ({1'b0, div} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    return (div != ZERO_V) && ({1'b0, cnt} < half);
  endfunction

  logic            cfg_valid_s;
  logic [N_CH-1:0] apply_vec_s;
  logic [LCW-1:0]  lock_cnt_r;
  logic [LCW-1:0]  lock_cnt_s;
  logic            cfg_err_r;
  logic            locked_r;

  assign cfg_valid_s = ({1'b0, cfg_ch} < 5'(N_CH));

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam logic [3:0] CH_IDX = 4'(gi);

    logic [DIV_W-1:0] div_r, phase_r, cnt_r, sh_div_r, sh_phase_r;
    logic [DIV_W-1:0] div_s, phase_s, cnt_s, sh_div_s, sh_phase_s;
    logic             pend_r, tick_r, clk_r;
    logic             pend_s, wr_hit_s, at_end_s, apply_s;

    assign wr_hit_s = cfg_wr && cfg_valid_s && (cfg_ch == CH_IDX);

    // Channel next state: natural count, period-end apply, or sync apply.
    always_comb begin
      at_end_s = (div_r <= ONE_V) || (cnt_r == div_r - ONE_V);
      apply_s  = sync_i || (pend_r && at_end_s);
      div_s    = div_r;
      phase_s  = phase_r;
      if (sync_i) begin
        if (wr_hit_s) begin
          div_s   = cfg_div;
          phase_s = cfg_phase;
        end else if (pend_r) begin
          div_s   = sh_div_r;
          phase_s = sh_phase_r;
        end else begin
          div_s   = div_r;
          phase_s = phase_r;
        end
      end else if (apply_s) begin
        div_s   = sh_div_r;
        phase_s = sh_phase_r;
      end else begin
        div_s   = div_r;
        phase_s = phase_r;
      end

      if (apply_s)       cnt_s = clamp_phase(phase_s, div_s);
      else if (at_end_s) cnt_s = ZERO_V;
      else               cnt_s = cnt_r + ONE_V;

      if (sync_i)        pend_s = 1'b0;
      else if (wr_hit_s) pend_s = 1'b1;
      else if (apply_s)  pend_s = 1'b0;
      else               pend_s = pend_r;

      if (wr_hit_s) begin
        sh_div_s   = cfg_div;
        sh_phase_s = cfg_phase;
      end else begin
        sh_div_s   = sh_div_r;
        sh_phase_s = sh_phase_r;
      end
    end

    // Channel registers; outputs derive from the same next state so they track cnt.
    always_ff @(posedge refclk) begin
      if (!rst_n) begin
        div_r      <= DEF_DIV_V;
        phase_r    <= ZERO_V;
        cnt_r      <= ZERO_V;
        sh_div_r   <= ZERO_V;
        sh_phase_r <= ZERO_V;
        pend_r     <= 1'b0;
        tick_r     <= 1'b0;
        clk_r      <= 1'b0;
      end else begin
        div_r      <= div_s;
        phase_r    <= phase_s;
        cnt_r      <= cnt_s;
        sh_div_r   <= sh_div_s;
        sh_phase_r <= sh_phase_s;
        pend_r     <= pend_s;
        tick_r     <= tick_level(cnt_s, div_s);
        clk_r      <= clk_level(cnt_s, div_s);
      end
    end

    assign tick_o[gi]      = tick_r;
    assign clk_o[gi]       = clk_r;
    assign pending_o[gi]   = pend_r;
    assign apply_vec_s[gi] = apply_s;
  end

  // Settle counter: restarts on any apply, counts while nothing is pending.
  always_comb begin
    if (|apply_vec_s)
      lock_cnt_s = {LCW{1'b0}};
    else if ((pending_o == {N_CH{1'b0}}) && (lock_cnt_r < LOCK_V))
      lock_cnt_s = lock_cnt_r + LCNT_ONE;
    else
      lock_cnt_s = lock_cnt_r;
  end

  // Lock flag and bad-channel error pulse.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      lock_cnt_r <= {LCW{1'b0}};
      locked_r   <= 1'b0;
      cfg_err_r  <= 1'b0;
    end else begin
      lock_cnt_r <= lock_cnt_s;
      locked_r   <= (lock_cnt_s == LOCK_V);
      cfg_err_r  <= cfg_wr && !cfg_valid_s;
    end
  end

  assign locked  = locked_r;
  assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: reset, ratio changes, sync, bad channel,
// disabled/bypass ratios and mid-period reset.
module tb_clk_div_bank;

  logic        refclk = 1'b0;
  logic        rst_n;
  logic        cfg_wr;
  logic [3:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [15:0] cfg_phase;
  logic        sync_i;
  logic [7:0]  tick_o;
  logic [7:0]  clk_o;
  logic [7:0]  pending_o;
  logic        cfg_err;
  logic        locked;

  int n_tests = 0;
  int n_fail  = 0;

  clk_div_bank #(.N_CH(8), .DIV_W(16), .DEF_DIV(10), .LOCK_CYCLES(16)) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase), .sync_i(sync_i),
    .tick_o(tick_o), .clk_o(clk_o), .pending_o(pending_o),
    .cfg_err(cfg_err), .locked(locked)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge refclk);
    #1;
  endtask

  task automatic wr(input logic [3:0] ch, input logic [15:0] d, input logic [15:0] p);
    cfg_wr    = 1'b1;
    cfg_ch    = ch;
    cfg_div   = d;
    cfg_phase = p;
  endtask

  initial begin
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_ch = 4'd0; cfg_div = 16'd0;
    cfg_phase = 16'd0; sync_i = 1'b0;
    repeat (3) cyc();
    check("rst_tick",    32'(tick_o),    32'h0);
    check("rst_clk",     32'(clk_o),     32'h0);
    check("rst_pending", 32'(pending_o), 32'h0);
    check("rst_locked",  32'(locked),    32'h0);
    check("rst_cfg_err", 32'(cfg_err),   32'h0);

    // Reset release: every channel at DEF_DIV=10
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      check("t1_tick", 32'(tick_o), (k % 10 == 9) ? 32'hFF : 32'h00);
      check("t1_clk",  32'(clk_o),  (k % 10 < 5)  ? 32'hFF : 32'h00);
      if (k == 15) check("t1_locked_lo", 32'(locked), 32'h0);
      if (k == 16) check("t1_locked_hi", 32'(locked), 32'h1);
    end

    // ch2 div=4 written together with sync: applied immediately
    wr(4'd2, 16'd4, 16'd0);
    sync_i = 1'b1;
    cyc();
    cfg_wr = 1'b0; sync_i = 1'b0;
    check("t2_sync_pending", 32'(pending_o), 32'h0);
    check("t2_sync_tick2",   32'(tick_o[2]), 32'h0);
    check("t2_sync_clk2",    32'(clk_o[2]),  32'h1);
    cyc();
    wr(4'd2, 16'd6, 16'd0);
    for (int s = 2; s <= 15; s++) begin
      cyc();
      if (s == 2) cfg_wr = 1'b0;
      check("t2_tick2", 32'(tick_o[2]), (s == 3 || s == 9 || s == 15) ? 32'h1 : 32'h0);
      check("t2_clk2",  32'(clk_o[2]),
            (s == 4 || s == 5 || s == 6 || s == 10 || s == 11 || s == 12) ? 32'h1 : 32'h0);
      check("t2_tick0", 32'(tick_o[0]), (s == 9) ? 32'h1 : 32'h0);
      if (s <= 4) check("t2_pending2", 32'(pending_o[2]), (s < 4) ? 32'h1 : 32'h0);
    end

    // ch0 div=8 phase=3 then sync
    wr(4'd0, 16'd8, 16'd3);
    cyc();
    cfg_wr = 1'b0;
    check("t3_pending0", 32'(pending_o[0]), 32'h1);
    sync_i = 1'b1;
    cyc();
    sync_i = 1'b0;
    check("t3_pending",  32'(pending_o), 32'h0);
    check("t3_tick0_t0", 32'(tick_o[0]), 32'h0);
    check("t3_clk0_t0",  32'(clk_o[0]),  32'h1);
    check("t3_locked0",  32'(locked),    32'h0);
    for (int t = 1; t <= 20; t++) begin
      cyc();
      if (t == 17) cfg_wr = 1'b0;
      check("t3_tick0", 32'(tick_o[0]), (t == 4 || t == 12 || t == 20) ? 32'h1 : 32'h0);
      if (t == 1)  check("t3_clk0_t1", 32'(clk_o[0]), 32'h0);
      if (t == 15) check("t3_locked_lo", 32'(locked), 32'h0);
      if (t == 16) begin
        check("t3_locked_hi", 32'(locked), 32'h1);
        wr(4'd12, 16'd3, 16'd0);
      end
      if (t == 17) begin
        check("t4_cfg_err_hi", 32'(cfg_err),   32'h1);
        check("t4_locked",     32'(locked),    32'h1);
        check("t4_pending",    32'(pending_o), 32'h0);
      end
      if (t == 18) begin
        check("t4_cfg_err_lo", 32'(cfg_err), 32'h0);
        check("t4_locked2",    32'(locked),  32'h1);
      end
    end

    // ch1 disabled via sync, then div=1 bypass
    wr(4'd1, 16'd0, 16'd0);
    sync_i = 1'b1;
    for (int u = 0; u <= 12; u++) begin
      cyc();
      if (u == 0) begin
        cfg_wr = 1'b0; sync_i = 1'b0;
      end
      check("t5_off1", 32'({tick_o[1], clk_o[1]}), 32'h0);
    end
    wr(4'd1, 16'd1, 16'd0);
    cyc();
    cfg_wr = 1'b0;
    check("t5_pending1", 32'(pending_o[1]), 32'h1);
    check("t5_tick1_w",  32'(tick_o[1]),    32'h0);
    for (int u = 14; u <= 16; u++) begin
      cyc();
      check("t5_tick1", 32'(tick_o[1]), 32'h1);
      check("t5_clk1",  32'(clk_o[1]),  32'h1);
      if (u == 14) check("t5_pending1_clr", 32'(pending_o[1]), 32'h0);
    end

    // Pending write on ch3 dropped by mid-period reset
    wr(4'd3, 16'd5, 16'd0);
    cyc();
    cfg_wr = 1'b0;
    check("t6_pending3", 32'(pending_o[3]), 32'h1);
    rst_n = 1'b0;
    cyc();
    check("t6_rst_tick",    32'(tick_o),    32'h0);
    check("t6_rst_clk",     32'(clk_o),     32'h0);
    check("t6_rst_pending", 32'(pending_o), 32'h0);
    check("t6_rst_locked",  32'(locked),    32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check("t6_tick", 32'(tick_o), (k == 9) ? 32'hFF : 32'h00);
      check("t6_clk",  32'(clk_o),  (k < 5 || k == 10) ? 32'hFF : 32'h00);
      if (k == 1) check("t6_pending", 32'(pending_o), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
